seq_bk_subtractor: RTL and testbench

- Multi-cycle wide subtractor: diff = a - b - bin over NUM_SLICES*8 bits, one 8-bit slice per cycle, borrow carried between cycles.
- Each slice is an 8-bit Brent-Kung prefix add of a + ~b + carry_in, built from the existing pre/black/grey/post cells.
- Sits between an operand producer and a result consumer, with valid/ready on both sides.

---
 rtl/seq_bk_subtractor_pkg.sv | 50 +++++
 rtl/seq_bk_subtractor_slice.sv | 66 ++++++
 rtl/seq_bk_subtractor.sv | 140 ++++++++++++++
 tb/tb_seq_bk_subtractor.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seq_bk_subtractor_pkg.sv
// Shared types and prefix-tree cell functions for the sequential
// Brent-Kung subtractor.
package seq_bk_subtractor_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Generate/propagate pair carried through the prefix tree.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Per-bit generate/propagate from the two addend bits.
    function automatic gp_t pre_node(input logic x, input logic y);
        gp_t r;
        r.g = x & y;
        r.p = x ^ y;
        return r;
    endfunction

    // Carry-in enters the tree as a pure generate below bit 0.
    function automatic logic fake_pre(input logic cin);
        return cin;
    endfunction

    // Combines a higher group with a lower group, keeping both g and p.
    function automatic gp_t black(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    // Combines a group with a terminal generate; only the carry is needed.
    function automatic logic grey(input gp_t hi, input logic lo_g);
        return hi.g | (hi.p & lo_g);
    endfunction

    // Sum bit from the bit propagate and the incoming carry.
    function automatic logic post_node(input logic p, input logic c);
        return p ^ c;
    endfunction

endpackage

// File: rtl/seq_bk_subtractor_slice.sv
// 8-bit Brent-Kung prefix adder with carry-in, purely combinational.
module bk_slice_add8
    import seq_bk_subtractor_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    gp_t        bit_gp [8];
    gp_t        grp    [8];
    logic [8:0] carry;

    gp_t g10, g32, g54, g76;
    gp_t g30, g74;
    gp_t g70;
    gp_t g50;
    gp_t g20, g40, g60;

    genvar gi;

    // Bit-level generate/propagate.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pre
            assign bit_gp[gi] = pre_node(a[gi], b[gi]);
        end
    endgenerate

    // Up-sweep: pairs, quads, then the full octet.
    assign g10 = black(bit_gp[1], bit_gp[0]);
    assign g32 = black(bit_gp[3], bit_gp[2]);
    assign g54 = black(bit_gp[5], bit_gp[4]);
    assign g76 = black(bit_gp[7], bit_gp[6]);
    assign g30 = black(g32, g10);
    assign g74 = black(g76, g54);
    assign g70 = black(g74, g30);

    // Down-sweep fills in the remaining prefixes.
    assign g50 = black(g54, g30);
    assign g20 = black(bit_gp[2], g10);
    assign g40 = black(bit_gp[4], g30);
    assign g60 = black(bit_gp[6], g50);

    assign grp[0] = bit_gp[0];
    assign grp[1] = g10;
    assign grp[2] = g20;
    assign grp[3] = g30;
    assign grp[4] = g40;
    assign grp[5] = g50;
    assign grp[6] = g60;
    assign grp[7] = g70;

    // Fold the carry-in into every prefix, then form the sum bits.
    assign carry[0] = fake_pre(cin);
    generate
        for (gi = 0; gi < 8; gi++) begin : g_post
            assign carry[gi+1] = grey(grp[gi], carry[0]);
            assign sum[gi]     = post_node(bit_gp[gi].p, carry[gi]);
        end
    endgenerate

    assign cout = carry[8];

endmodule

// File: rtl/seq_bk_subtractor.sv
// Multi-cycle wide subtractor: diff = a - b - bin, one 8-bit slice per
// cycle with the borrow carried (as an inverted carry) between cycles.
module seq_bk_subtractor
    import seq_bk_subtractor_pkg::*;
#(
    parameter int NUM_SLICES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_SLICES*SLICE_W-1:0] a,
    input  logic [NUM_SLICES*SLICE_W-1:0] b,
    input  logic                          bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_SLICES*SLICE_W-1:0] diff,
    output logic                          bout,
    output logic                          ovf,
    output logic                          zero
);

    localparam int W     = NUM_SLICES * SLICE_W;
    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic               carry_reg;
    logic [W-1:0]       diff_reg;
    logic               out_valid_reg;
    logic               bout_reg;
    logic               ovf_reg;
    logic               zero_reg;

    logic [SLICE_W-1:0] a_slices [NUM_SLICES];
    logic [SLICE_W-1:0] b_slices [NUM_SLICES];
    logic [SLICE_W-1:0] cur_a;
    logic [SLICE_W-1:0] cur_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic [W-1:0]       diff_next;
    logic               ovf_next;
    logic               zero_next;

    genvar gi;

    // Split the latched operands into slices for index-based selection.
    generate
        for (gi = 0; gi < NUM_SLICES; gi++) begin : g_slices
            assign a_slices[gi] = a_reg[gi*SLICE_W +: SLICE_W];
            assign b_slices[gi] = b_reg[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign cur_a = a_slices[idx_reg];
    assign cur_b = b_slices[idx_reg];

    // Subtraction as a + ~b + carry; carry starts as ~bin.
    bk_slice_add8 u_slice (
        .a    (cur_a),
        .b    (~cur_b),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Result as it will look after this cycle's slice is written back.
    generate
        for (gi = 0; gi < NUM_SLICES; gi++) begin : g_diff_next
            assign diff_next[gi*SLICE_W +: SLICE_W] =
                (idx_reg == IDX_W'(gi)) ? slice_sum
                                        : diff_reg[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    // Flags on the final result, valid when the last slice is being written.
    assign ovf_next  = (a_reg[W-1] != b_reg[W-1]) & (diff_next[W-1] != a_reg[W-1]);
    assign zero_next = ~|diff_next;

    // Control FSM plus operand/result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            out_valid_reg <= 1'b0;
            diff_reg      <= '0;
            bout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            zero_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= ~bin;
                        idx_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    diff_reg  <= diff_next;
                    carry_reg <= slice_cout;
                    idx_reg   <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        bout_reg      <= ~slice_cout;
                        ovf_reg       <= ovf_next;
                        zero_reg      <= zero_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign diff      = diff_reg;
    assign bout      = bout_reg;
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_seq_bk_subtractor.sv
// Directed bench for seq_bk_subtractor with NUM_SLICES = 4.
module tb_seq_bk_subtractor;

    localparam int NS = 4;
    localparam int W  = NS * 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    int compared   = 0;
    int mismatched = 0;

    seq_bk_subtractor #(.NUM_SLICES(NS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid; returns the number of cycles waited (bounded).
    task automatic wait_out(output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 20) begin
            step();
            cycles++;
        end
    endtask

    // Full operation: accept, check latency and results, then drain.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bi, input logic [W-1:0] ed, input logic eb,
                          input logic eo, input logic ez);
        int cyc;
        chk({tag, "_in_ready"}, W'(in_ready), W'(1));
        a = av; b = bv; bin = bi; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = '1; b = '1; bin = 1'b1;
        chk({tag, "_busy"}, W'(in_ready), W'(0));
        // Already one cycle into the operation after the accept edge.
        wait_out(cyc);
        chk({tag, "_latency"}, W'(cyc + 1), W'(NS + 1));
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_bout"}, W'(bout), W'(eb));
        chk({tag, "_ovf"},  W'(ovf),  W'(eo));
        chk({tag, "_zero"}, W'(zero), W'(ez));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, W'(out_valid), W'(0));
        chk({tag, "_drain_ready"}, W'(in_ready), W'(1));
    endtask

    initial begin
        int cyc;
        logic [W-1:0] held;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_in_ready",  W'(in_ready),  W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_diff",      diff,          W'(0));
        chk("rst_flags",     W'({bout, ovf, zero}), W'(0));

        run_op("basic",  32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        run_op("ripple", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op("ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_op("zero",   32'h1234_5678, 32'h1234_5677, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1);

        // Backpressure: result held while out_ready=0, new request waits.
        a = 32'h0000_0100; b = 32'h0000_0001; bin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(cyc);
        chk("bp_latency", W'(cyc + 1), W'(NS + 1));
        chk("bp_diff", diff, 32'h0000_00FF);
        held = diff;
        a = 32'h0000_0020; b = 32'h0000_0030; bin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_diff",  diff, held);
            chk("bp_hold_flags", W'({bout, ovf, zero}), W'(0));
            chk("bp_hold_valid", W'(out_valid), W'(1));
            chk("bp_hold_ready", W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_idle_ready", W'(in_ready), W'(1));
        chk("bp_idle_valid", W'(out_valid), W'(0));
        step();
        in_valid = 1'b0;
        chk("bp_accepted", W'(in_ready), W'(0));
        wait_out(cyc);
        chk("bp2_latency", W'(cyc + 1), W'(NS + 1));
        chk("bp2_diff", diff, 32'hFFFF_FFF0);
        chk("bp2_bout", W'(bout), W'(1));
        chk("bp2_ovf",  W'(ovf),  W'(0));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset during the second RUN cycle aborts the operation.
        a = 32'h0000_0055; b = 32'h0000_0011; bin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_in_ready",  W'(in_ready),  W'(1));
        chk("abort_out_valid", W'(out_valid), W'(0));
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid !== 1'b0) cyc++;
        end
        chk("abort_no_result", W'(cyc), W'(0));
        run_op("post_abort", 32'h0000_0010, 32'h0000_0001, 1'b0, 32'h0000_000F, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
